// File: rtl/core_config.sv
// Core-wide configuration: address/line widths and AXI encodings.
package core_config;

    localparam int ADDR_WIDTH       = 32;
    localparam int ICACHELINE_WIDTH = 128;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Refill bursts always start on a 16-byte line boundary.
    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/icache_refill_axi.sv
// I-cache line refill over an AXI read channel: one 4-beat INCR burst per line.
// Optional bus-error tracking via ICACHE_RRESP_CHECK_EN.
module icache_refill_axi
    import core_config::*;
#(
    parameter logic [3:0] ARID = 4'h0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rreq_i,
    input  logic [ADDR_WIDTH-1:0]       raddr_i,
    output logic                        rdy_o,
    output logic                        rvalid_o,
    output logic [1:0]                  rlast_o,
    output logic [ICACHELINE_WIDTH-1:0] rdata_o,
    output logic [3:0]                  m_axi_arid,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [3:0]                  m_axi_rid,
    input  logic [31:0]                 m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic                        err_o
);

    localparam int BEATS  = 4;
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]                  state;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [BEAT_W-1:0]           beat_cnt;
    logic [ICACHELINE_WIDTH-1:0] line_buf;
    logic [ICACHELINE_WIDTH-1:0] line_nxt;
    logic [ICACHELINE_WIDTH-1:0] line_out;
    logic                        beat_ok;
    logic                        unused_low;

    assign unused_low = ^raddr_i[3:0];

    assign rdy_o   = (state == IDLE) & rreq_i;
    assign beat_ok = (state == R) & m_axi_rvalid & (m_axi_rid == ARID);

    always_comb begin
        line_nxt = line_buf;
        if (beat_ok) begin
            line_nxt[{beat_cnt, 5'd0} +: 32] = m_axi_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            beat_cnt <= '0;
            line_buf <= '0;
            line_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy_o) begin
                        addr_q   <= line_base(raddr_i);
                        line_buf <= '0;
                        beat_cnt <= '0;
                        state    <= AR;
                    end
                end
                AR: begin
                    if (m_axi_arready) begin
                        state <= R;
                    end
                end
                R: begin
                    if (beat_ok) begin
                        line_buf <= line_nxt;
                        if (beat_cnt != BEAT_W'(BEATS - 1)) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        // Output register only changes on line completion so it holds between refills.
                        if (m_axi_rlast) begin
                            line_out <= line_nxt;
                            state    <= RESP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axi_arvalid = (state == AR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arid    = ARID;
    assign m_axi_rready  = (state == R);

    assign rvalid_o = (state == RESP);
    assign rlast_o  = rvalid_o ? 2'b01 : 2'b00;
    assign rdata_o  = line_out;

`ifdef ICACHE_RRESP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (beat_ok && (m_axi_rresp != AXI_RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_rresp;

    assign unused_rresp = ^m_axi_rresp;
    assign err_o        = 1'b0;
`endif

endmodule

// File: doc/icache_refill_axi.md
ICACHE_REFILL_AXI -- requirements
Module: icache_refill_axi

Interface
REQ-001 Parameters SHALL be: ARID, 4'h0, AXI ID driven on every read burst; BEATS, 4, beats per 128-bit line (fixed, not user-tunable).
REQ-002 clk  input  1  sole clock, all logic on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rreq_i  input  1  icache line refill request, held until rvalid_o.
REQ-005 raddr_i  input  ADDR_WIDTH  physical line address.
REQ-006 rdy_o  output  1  request accepted this cycle.
REQ-007 rvalid_o  output  1  line data valid, one-cycle pulse.
REQ-008 rlast_o  output  2  line-complete flags.
REQ-009 rdata_o  output  ICACHELINE_WIDTH  assembled 128-bit line.
REQ-010 m_axi_arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1: outputs; m_axi_arready 1: input.
REQ-011 m_axi_rid 4, rdata 32, rresp 2, rlast 1, rvalid 1: inputs; m_axi_rready 1: output.
REQ-012 err_o  output  1  sticky bus-error flag.

Function
REQ-013 FSM states SHALL be IDLE, AR, R, RESP.
REQ-014 rdy_o SHALL be combinational: (state==IDLE) & rreq_i; IDLE->AR on rdy_o.
REQ-015 On accept, raddr_i SHALL be latched with bits [3:0] forced to 0, and the line buffer SHALL be cleared to 0.
REQ-016 In AR: arvalid=1, araddr=latched address, arlen=3, arsize=3'b010, arburst=2'b01, arid=ARID; AR->R on arvalid&arready; arvalid SHALL stay high until the handshake.
REQ-017 In R: rready=1; beats with rid!=ARID SHALL be consumed without side effect.
REQ-018 Matching beat k (2-bit counter from 0) SHALL be written to rdata bits [32k+31:32k]; the counter saturates at 3.
REQ-019 A matching beat with rlast=1 SHALL move R->RESP; early rlast leaves the unwritten words 0.
REQ-020 RESP SHALL last one cycle with rvalid_o=1, rlast_o=2'b01, rdata_o=buffer; then RESP->IDLE.
REQ-021 rdy_o SHALL be 0 in AR, R, RESP; no second request overlaps.
REQ-022 Minimum latency with zero-wait AXI: accept at cycle 0, AR handshake cycle 1, beats cycles 2-5, rvalid_o cycle 6.
REQ-023 rdata_o SHALL hold its last line outside RESP; rvalid_o and rlast_o SHALL be 0 outside RESP.
REQ-024 rreq_i deassertion after accept SHALL NOT abort the burst; the line is still returned.

Reset
REQ-025 rst SHALL force state IDLE, arvalid=0, rready=0, rvalid_o=0, rlast_o=0, rdata_o=0, beat counter=0, err_o=0.
REQ-026 Reset mid-burst SHALL abandon the burst at the next edge; the interconnect is reset together, and residual beats are not tracked.

Configuration
REQ-027 Macro ICACHE_RRESP_CHECK_EN: when defined, any matching beat with rresp!=2'b00 SHALL set err_o (sticky until rst), and the line SHALL still complete normally.
REQ-028 When ICACHE_RRESP_CHECK_EN is undefined, err_o SHALL be tied 0 and rresp SHALL be ignored.

Structure
REQ-029 ADDR_WIDTH and ICACHELINE_WIDTH SHALL come from core_config; AXI encodings (AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY) SHALL be added to core_config.
REQ-030 No sub-module; FSM, beat counter and line buffer are single-module logic.

Verification
REQ-031 raddr_i=32'h1C00_0024, zero-wait slave -> araddr=32'h1C00_0020, arlen=3, rvalid_o at cycle 6, rdata_o={D3,D2,D1,D0}.
REQ-032 arready delayed 5 cycles -> arvalid and araddr stable for those 5 cycles, one AR handshake only.
REQ-033 rvalid gaps (beats at cycles 2,4,7,9) -> correct word placement, rvalid_o one cycle after beat 4.
REQ-034 Foreign rid=4'h5 beat interleaved -> ignored, line unchanged.
REQ-035 rst asserted during beat 2 -> all outputs 0 next cycle, new request accepted afterwards.
REQ-036 With ICACHE_RRESP_CHECK_EN, rresp=2'b10 on beat 1 -> err_o=1 persists, rvalid_o still pulses; without the macro, err_o=0.
